// File: rtl/hyper_lsab_dram_multi.sv
// hyper_lsab_dram_multi: DRAM-side LSAB block command sequencer with multi-channel
// MCU alignment and optional page-boundary auto split.
module hyper_lsab_dram_multi #(
   parameter int ADDR_W = 32,
   parameter int PAGE_W = 12,
   parameter int LEN_W  = 6,
   parameter int SECT_W = 2,
   parameter int N_DRAM = 2,
   parameter int DSEL_W = 1
)(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     GO,
   input  logic [LEN_W-1:0]         BLOCK_LENGTH,
   input  logic [ADDR_W-1:0]        NEW_ADDR,
   input  logic [SECT_W-1:0]        NEW_SECTION,
   input  logic [DSEL_W-1:0]        NEW_DRAM,
   input  logic                     AUTO_SPLIT,
   output logic [ADDR_W-1:0]        OLD_ADDR,
   output logic                     READY,
   output logic                     ENDOF_PAGE,
   output logic [LEN_W-1:0]         COUNT_SENT,
   output logic [PAGE_W-1:0]        BLCK_START,
   output logic [LEN_W-1:0]         BLCK_COUNT_REQ,
   output logic                     BLCK_ISSUE,
   output logic [SECT_W-1:0]        BLCK_SECTION,
   input  logic [LEN_W-1:0]         BLCK_COUNT_SENT,
   input  logic                     BLCK_WORKING,
   output logic [ADDR_W-PAGE_W-1:0] MCU_PAGE_ADDR,
   output logic [N_DRAM-1:0]        MCU_REQUEST_ALIGN,
   input  logic [N_DRAM-1:0]        MCU_GRANT_ALIGN
);
   localparam int PW1 = PAGE_W + 1;
   localparam int PG_W = ADDR_W - PAGE_W;
   localparam logic [PAGE_W:0] PAGE_SZ = {1'b1, {PAGE_W{1'b0}}};
   typedef enum logic [2:0] {IDLE, LOAD, CALC, ALIGN, WAIT, NEXT, FINISH} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] addr_l;
   logic [LEN_W-1:0]  len_l, remaining, total, req_len, rem_next;
   logic [SECT_W-1:0] sect_l;
   logic [DSEL_W-1:0] dram_l;
   logic [PAGE_W:0]   end_w;
   logic              split_l, prev_working, at_end_r, done, at_end_w, grant_ok;
   assign READY = state == IDLE;
   always_comb begin
      end_w    = {1'b0, BLCK_START} + PW1'(remaining);
      req_len  = end_w > PAGE_SZ ? LEN_W'(PAGE_SZ - {1'b0, BLCK_START}) : remaining;
      done     = prev_working && !BLCK_WORKING;
      at_end_w = (BLCK_COUNT_SENT == BLCK_COUNT_REQ) &&
                 ({1'b0, BLCK_START} + PW1'(BLCK_COUNT_REQ) == PAGE_SZ);
      rem_next = remaining - BLCK_COUNT_SENT;
      grant_ok = MCU_GRANT_ALIGN[dram_l] && !BLCK_WORKING && !prev_working;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = GO ? LOAD : IDLE;
         LOAD:    state_n = len_l == '0 ? FINISH : CALC;
         CALC:    state_n = ALIGN;
         ALIGN:   state_n = grant_ok ? WAIT : ALIGN;
         WAIT:    state_n = !done ? WAIT :
                            (split_l && at_end_w && rem_next != '0) ? NEXT : FINISH;
         NEXT:    state_n = CALC;
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_n;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         addr_l            <= '0;
         len_l             <= '0;
         sect_l            <= '0;
         dram_l            <= '0;
         split_l           <= 1'b0;
         remaining         <= '0;
         total             <= '0;
         at_end_r          <= 1'b0;
         prev_working      <= 1'b0;
         OLD_ADDR          <= '0;
         ENDOF_PAGE        <= 1'b0;
         COUNT_SENT        <= '0;
         BLCK_START        <= '0;
         BLCK_COUNT_REQ    <= '0;
         BLCK_ISSUE        <= 1'b0;
         BLCK_SECTION      <= '0;
         MCU_PAGE_ADDR     <= '0;
         MCU_REQUEST_ALIGN <= '0;
      end else begin
         prev_working <= BLCK_WORKING;
         BLCK_ISSUE   <= state == ALIGN && grant_ok;
         case (state)
            IDLE: if (GO) begin
               addr_l  <= NEW_ADDR;
               len_l   <= BLOCK_LENGTH;
               sect_l  <= NEW_SECTION;
               dram_l  <= NEW_DRAM;
               split_l <= AUTO_SPLIT;
            end
            LOAD: begin
               MCU_PAGE_ADDR <= addr_l[ADDR_W-1:PAGE_W];
               BLCK_START    <= addr_l[PAGE_W-1:0];
               BLCK_SECTION  <= sect_l;
               remaining     <= len_l;
               total         <= '0;
               at_end_r      <= 1'b0;
            end
            CALC: begin
               BLCK_COUNT_REQ    <= req_len;
               MCU_REQUEST_ALIGN <= N_DRAM'(1) << dram_l;
            end
            WAIT: if (done) begin
               total             <= total + BLCK_COUNT_SENT;
               remaining         <= rem_next;
               at_end_r          <= at_end_w;
               MCU_REQUEST_ALIGN <= '0;
            end
            // request drops only for the NEXT cycle before the following chunk
            NEXT: begin
               MCU_PAGE_ADDR     <= MCU_PAGE_ADDR + PG_W'(1);
               BLCK_START        <= '0;
               MCU_REQUEST_ALIGN <= N_DRAM'(1) << dram_l;
            end
            FINISH: begin
               OLD_ADDR          <= addr_l + ADDR_W'(total);
               COUNT_SENT        <= total;
               ENDOF_PAGE        <= at_end_r;
               MCU_REQUEST_ALIGN <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/hyper_lsab_dram_multi.md
Name: hyper_lsab_dram_multi

Overview:
Parametrised successor of the DRAM-side LSAB command sequencer.
- Accepts one block command from the hyper scheduler (address, length, section, target DRAM).
- Requests MCU alignment on one of N_DRAM channels, issues the block to the block mover and waits for it to finish.
- Reports the resume address, the count sent and the end-of-page status.
- New over the previous generation: widths are parametrised; there are multiple DRAM align channels; an optional AUTO_SPLIT mode continues across a page boundary inside the block, with no scheduler round-trip.

Parameters:
- ADDR_W, 32, byte/word address width.
- PAGE_W, 12, in-page offset width; page size is 2^PAGE_W.
- LEN_W, 6, block length / count width; LEN_W < PAGE_W.
- SECT_W, 2, section selector width.
- N_DRAM, 2, number of MCU align channels.
- DSEL_W, 1, DRAM select width; max(1, clog2(N_DRAM)).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- GO  in  1  start command; sampled only while READY=1.
- BLOCK_LENGTH  in  LEN_W  words requested.
- NEW_ADDR  in  ADDR_W  start address.
- NEW_SECTION  in  SECT_W  section passed to the block mover.
- NEW_DRAM  in  DSEL_W  target DRAM channel index.
- AUTO_SPLIT  in  1  1 = continue across a page boundary.
- OLD_ADDR  out  ADDR_W  resume address (start + total sent).
- READY  out  1  idle, accepting GO.
- ENDOF_PAGE  out  1  command stopped exactly at a page end.
- COUNT_SENT  out  LEN_W  total words moved by the last command.
- BLCK_START  out  PAGE_W  in-page start offset of the current chunk.
- BLCK_COUNT_REQ  out  LEN_W  words requested for the current chunk.
- BLCK_ISSUE  out  1  one-cycle issue pulse to the block mover.
- BLCK_SECTION  out  SECT_W  latched section.
- BLCK_COUNT_SENT  in  LEN_W  words moved by the mover in the current chunk.
- BLCK_WORKING  in  1  block mover busy.
- MCU_PAGE_ADDR  out  ADDR_W-PAGE_W  page (row) address.
- MCU_REQUEST_ALIGN  out  N_DRAM  one-hot align request.
- MCU_GRANT_ALIGN  in  N_DRAM  align grants.

Behaviour:
- Reset (asynchronous, while RST=1): all outputs 0 except READY=1. State=IDLE, internal counters 0. Reset mid-operation aborts immediately and drops the request; the block mover is not notified.
- States: IDLE -> LOAD -> CALC -> ALIGN -> WAIT -> FINISH -> IDLE. AUTO_SPLIT adds a NEXT state.
- IDLE (READY=1): on GO, latch NEW_ADDR, BLOCK_LENGTH, NEW_SECTION, NEW_DRAM and AUTO_SPLIT; go to LOAD. GO is ignored outside IDLE.
- LOAD:
  - MCU_PAGE_ADDR = addr[ADDR_W-1:PAGE_W]; BLCK_START = addr[PAGE_W-1:0]; BLCK_SECTION latched.
  - remaining = length; total = 0.
  - If remaining = 0, go straight to FINISH: no request, no issue.
- CALC:
  - end = BLCK_START + remaining, computed PAGE_W+1 bits wide.
  - If end > 2^PAGE_W, BLCK_COUNT_REQ = 2^PAGE_W - BLCK_START; otherwise BLCK_COUNT_REQ = remaining.
  - Assert MCU_REQUEST_ALIGN[dram] (one-hot; other bits 0). Go to ALIGN.
- ALIGN: when MCU_GRANT_ALIGN[dram]=1, BLCK_WORKING=0 and registered prev BLCK_WORKING=0, pulse BLCK_ISSUE for exactly 1 cycle and go to WAIT. Grants on other channels are ignored.
- WAIT:
  - Completion = falling edge of BLCK_WORKING (prev=1, now=0).
  - On completion: total += BLCK_COUNT_SENT; remaining -= BLCK_COUNT_SENT; chunk_full = (BLCK_COUNT_SENT == BLCK_COUNT_REQ); at_end = chunk_full && (BLCK_START + BLCK_COUNT_REQ == 2^PAGE_W).
  - If AUTO_SPLIT && at_end && remaining != 0, go to NEXT; otherwise go to FINISH.
  - Grant deassertion during WAIT is ignored; the request is held.
- NEXT:
  - Deassert the request for this one cycle.
  - MCU_PAGE_ADDR += 1, modulo 2^(ADDR_W-PAGE_W); wraps all-ones to 0.
  - BLCK_START = 0; go to CALC.
- FINISH:
  - OLD_ADDR = start + total, modulo 2^ADDR_W.
  - COUNT_SENT = total; ENDOF_PAGE = at_end of the last chunk. This is 0 for a zero-length command and for any short chunk.
  - Drop the request. Go to IDLE; READY=1 the next cycle, with outputs already valid.
- A short chunk (sent < requested) always ends the command, even with AUTO_SPLIT=1.
- OLD_ADDR, COUNT_SENT and ENDOF_PAGE hold their values until the next FINISH.
- Latency, no-wait case: GO at cycle 0; READY=0 at cycle 1; request at cycle 3; earliest issue at cycle 4.

Test Plan:
- PAGE_W=12, LEN_W=6, N_DRAM=2. NEW_ADDR=0x00012040, len 16, DRAM 1, mover returns 16 -> REQ=2'b10, PAGE=0x00012, START=0x040, COUNT_REQ=16, single ISSUE pulse; OLD_ADDR=0x00012050, COUNT_SENT=16, ENDOF_PAGE=0.
- NEW_ADDR=0x00012FF0, len 32, AUTO_SPLIT=0, mover returns 16 -> COUNT_REQ=16; ENDOF_PAGE=1, OLD_ADDR=0x00013000, COUNT_SENT=16.
- Same command with AUTO_SPLIT=1 -> two ISSUE pulses (page 0x00012/start 0xFF0/16, then page 0x00013/start 0/16); REQ low exactly 1 cycle between them; COUNT_SENT=32, OLD_ADDR=0x00013010, ENDOF_PAGE=0.
- len 20, mover returns 7, AUTO_SPLIT=1 -> one ISSUE pulse; COUNT_SENT=7, OLD_ADDR=start+7, ENDOF_PAGE=0.
- NEW_ADDR=0xFFFFFFF8, len 16, AUTO_SPLIT=1 -> second chunk PAGE=0x00000; OLD_ADDR=0x00000008.
- Zero-length GO -> no REQ or ISSUE, READY back with COUNT_SENT=0. GO while busy -> ignored. Grant on the wrong channel -> no issue. RST pulse in WAIT -> REQ=0 and READY=1 immediately.
